// File: rtl/dcache_ctrl_if.sv
// Signal bundle tying dcache_ctrl to the CPU load/store port, the cache array and the memory bus.
interface dcache_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ready;
   logic [1:0]        dc_line;
   logic [2:0]        dc_blk;
   logic [7:0]        dc_din;
   logic              dc_wr;
   logic [7:0]        dc_dout;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, dc_dout, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, dc_line, dc_blk, dc_din, dc_wr,
             mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata, dc_dout, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, dc_line, dc_blk, dc_din, dc_wr,
             mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped 4x8-byte data cache controller: write-through, no-write-allocate,
// byte-serial line refill on read miss, saturating hit/miss statistics.
module dcache_ctrl #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   dcache_ctrl_if.slave bus
);
   localparam int TAG_W = ADDR_W - 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COMPARE = 3'd1,
      REFILL  = 3'd2,
      WTHRU   = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t            state_r, next_s;
   logic [3:0]        valid_r;
   logic [TAG_W-1:0]  tag_r [4];
   logic [ADDR_W-1:0] addr_r;
   logic              wr_r;
   logic [7:0]        wdata_r;
   logic [2:0]        cnt_r;
   logic              refill_r;
   logic [7:0]        rdata_r;
   logic [CNT_W-1:0]  hit_cnt_r, miss_cnt_r;

   logic [1:0]        idx_s;
   logic [2:0]        off_s;
   logic [TAG_W-1:0]  tag_s;
   logic              hit_s;
   logic [1:0]        dc_line_s;
   logic [2:0]        dc_blk_s;
   logic [7:0]        dc_din_s;
   logic              dc_wr_s;
   logic              mem_req_s, mem_we_s, cpu_ready_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [7:0]        mem_wdata_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign idx_s = addr_r[4:3];
   assign off_s = addr_r[2:0];
   assign tag_s = addr_r[ADDR_W-1:5];
   assign hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= next_s;
   end

   // Next-state and per-state drive of the array and memory bus
   always_comb begin
      next_s      = state_r;
      dc_line_s   = 2'd0;
      dc_blk_s    = 3'd0;
      dc_din_s    = 8'd0;
      dc_wr_s     = 1'b0;
      mem_req_s   = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = 8'd0;
      cpu_ready_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.cpu_req) next_s = COMPARE;
            else             next_s = IDLE;
         end
         COMPARE: begin
            dc_line_s = idx_s;
            dc_blk_s  = off_s;
            if (hit_s && wr_r) begin
               dc_wr_s  = 1'b1;
               dc_din_s = wdata_r;
               next_s   = WTHRU;
            end else if (hit_s) begin
               next_s = RESP;
            end else if (wr_r) begin
               next_s = WTHRU;
            end else begin
               next_s = REFILL;
            end
         end
         REFILL: begin
            dc_line_s  = idx_s;
            dc_blk_s   = cnt_r;
            mem_req_s  = 1'b1;
            mem_addr_s = {tag_s, idx_s, cnt_r};
            if (bus.mem_ack) begin
               dc_wr_s  = 1'b1;
               dc_din_s = bus.mem_rdata;
               if (cnt_r == 3'd7) next_s = COMPARE;
               else               next_s = REFILL;
            end else begin
               next_s = REFILL;
            end
         end
         WTHRU: begin
            mem_req_s   = 1'b1;
            mem_we_s    = 1'b1;
            mem_addr_s  = addr_r;
            mem_wdata_s = wdata_r;
            if (bus.mem_ack) next_s = RESP;
            else             next_s = WTHRU;
         end
         RESP: begin
            dc_line_s   = idx_s;
            dc_blk_s    = off_s;
            cpu_ready_s = 1'b1;
            next_s      = IDLE;
         end
         default: next_s = IDLE;
      endcase
   end

   // Request latch, tag/valid bookkeeping, load data and statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r    <= 4'd0;
         for (int i = 0; i < 4; i++) tag_r[i] <= {TAG_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
         wr_r       <= 1'b0;
         wdata_r    <= 8'd0;
         cnt_r      <= 3'd0;
         refill_r   <= 1'b0;
         rdata_r    <= 8'd0;
         hit_cnt_r  <= {CNT_W{1'b0}};
         miss_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.cpu_req) begin
                  addr_r   <= bus.cpu_addr;
                  wr_r     <= bus.cpu_wr;
                  wdata_r  <= bus.cpu_wdata;
                  refill_r <= 1'b0;
               end
            end
            COMPARE: begin
               if (hit_s) begin
                  // The re-compare after a refill serves the load but is not a new hit
                  if (!refill_r) hit_cnt_r <= sat_inc(hit_cnt_r);
                  if (!wr_r)     rdata_r   <= bus.dc_dout;
               end else begin
                  miss_cnt_r <= sat_inc(miss_cnt_r);
                  if (!wr_r) begin
                     valid_r[idx_s] <= 1'b0;
                     tag_r[idx_s]   <= tag_s;
                     cnt_r          <= 3'd0;
                  end
               end
            end
            REFILL: begin
               if (bus.mem_ack) begin
                  cnt_r <= cnt_r + 3'd1;
                  if (cnt_r == 3'd7) begin
                     valid_r[idx_s] <= 1'b1;
                     refill_r       <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cpu_rdata = rdata_r;
   assign bus.cpu_ready = cpu_ready_s;
   assign bus.dc_line   = dc_line_s;
   assign bus.dc_blk    = dc_blk_s;
   assign bus.dc_din    = dc_din_s;
   assign bus.dc_wr     = dc_wr_s;
   assign bus.mem_req   = mem_req_s;
   assign bus.mem_we    = mem_we_s;
   assign bus.mem_addr  = mem_addr_s;
   assign bus.mem_wdata = mem_wdata_s;
   assign bus.hit_cnt   = hit_cnt_r;
   assign bus.miss_cnt  = miss_cnt_r;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: cache-array and memory models, directed table,
// held-request and reset corner sequences, and a random run against a cache reference model.
module tb_dcache_ctrl;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 6;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   dcache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
   dcache_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {logic we; logic [7:0] addr; logic [7:0] data;} xfer_t;
   typedef struct packed {logic [1:0] line; logic [2:0] blk; logic [7:0] din;} dcw_t;
   typedef struct {logic wr; logic [7:0] addr; logic [7:0] wdata; int w; logic [7:0] exp_rd; logic exp_hit;} vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_wait = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cache array: combinational read, write on dc_wr; every write is logged
   logic [7:0] arr [32];
   dcw_t dq[$];
   always @(posedge clk) begin
      if (bus.dc_wr) begin
         arr[{bus.dc_line, bus.dc_blk}] <= bus.dc_din;
         dq.push_back(dcw_t'{bus.dc_line, bus.dc_blk, bus.dc_din});
      end
   end
   assign bus.dc_dout = arr[{bus.dc_line, bus.dc_blk}];

   // Memory: unwritten bytes read as addr^0x5A; ack after mem_wait idle cycles per beat
   bit [7:0] wmem [256];
   bit       wmask [256];
   xfer_t    xq[$];
   int       wcnt = 0;
   int       stab_bad = 0;
   logic     p_we;
   logic [7:0] p_addr, p_wdata;
   always @(negedge clk) begin
      if (rst || !bus.mem_req) begin
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 8'd0;
         wcnt          = 0;
      end else begin
         if (wcnt > 0 && {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {p_we, p_addr, p_wdata})
            stab_bad++;
         if (wcnt >= mem_wait) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we) begin
               wmem[bus.mem_addr]  = bus.mem_wdata;
               wmask[bus.mem_addr] = 1'b1;
               xq.push_back(xfer_t'{1'b1, bus.mem_addr, bus.mem_wdata});
            end else begin
               bus.mem_rdata = wmask[bus.mem_addr] ? wmem[bus.mem_addr] : (bus.mem_addr ^ 8'h5A);
               xq.push_back(xfer_t'{1'b0, bus.mem_addr, bus.mem_rdata});
            end
            wcnt = 0;
         end else begin
            bus.mem_ack = 1'b0;
            p_we    = bus.mem_we;
            p_addr  = bus.mem_addr;
            p_wdata = bus.mem_wdata;
            wcnt++;
         end
      end
   end

   // Reference model: what the cache should hold, plus the backing memory image
   logic [7:0] ref_mem [256];
   logic [3:0] ref_valid;
   logic [2:0] ref_tag [4];
   int ref_hc, ref_mc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      ref_valid = 4'd0;
      for (int i = 0; i < 4; i++) ref_tag[i] = 3'd0;
      ref_hc = 0;
      ref_mc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic do_access(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                            input int w, output logic [7:0] rd);
      logic [1:0] idx;
      logic       hit;
      logic [7:0] ba;
      int         exp_cyc, cyc, xs, ds, nx, nd;
      bit         got;
      xfer_t      ex[$];
      dcw_t       ed[$];
      idx = a[4:3];
      hit = ref_valid[idx] && (ref_tag[idx] == a[7:5]);
      exp_cyc = 2;
      if (wr) begin
         ref_mem[a] = wd;
         ex.push_back(xfer_t'{1'b1, a, wd});
         if (hit) ed.push_back(dcw_t'{idx, a[2:0], wd});
         exp_cyc = w + 3;
      end else if (!hit) begin
         for (int k = 0; k < 8; k++) begin
            ba = {a[7:3], 3'(k)};
            ex.push_back(xfer_t'{1'b0, ba, ref_mem[ba]});
            ed.push_back(dcw_t'{idx, 3'(k), ref_mem[ba]});
         end
         exp_cyc = 8 * (w + 1) + 3;
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = a[7:5];
      end
      if (hit) ref_hc = (ref_hc == CMAX) ? CMAX : ref_hc + 1;
      else     ref_mc = (ref_mc == CMAX) ? CMAX : ref_mc + 1;

      @(negedge clk);
      mem_wait = w;
      xs = xq.size();
      ds = dq.size();
      bus.cpu_req   = 1'b1;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = a;
      bus.cpu_wdata = wd;
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge clk);
         cyc++;
         got = bus.cpu_ready;
      end
      chk("ready_seen", got, 1);
      chk("latency", cyc, exp_cyc);
      rd = bus.cpu_rdata;
      if (!wr) chk("rdata", rd, ref_mem[a]);
      @(negedge clk);
      chk("ready_pulse", bus.cpu_ready, 0);
      chk("hit_cnt", bus.hit_cnt, ref_hc);
      chk("miss_cnt", bus.miss_cnt, ref_mc);
      chk("mem_stable", stab_bad, 0);
      nx = xq.size() - xs;
      nd = dq.size() - ds;
      chk("xfer_count", nx, ex.size());
      for (int i = 0; i < ex.size() && i < nx; i++) chk("xfer", xq[xs+i], ex[i]);
      chk("dcw_count", nd, ed.size());
      for (int i = 0; i < ed.size() && i < nd; i++) chk("dc_write", dq[ds+i], ed[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [12];
      logic [7:0] rd;
      logic [CNT_W-1:0] h0;
      int n, xs, pulses;

      vt[0]  = '{1'b0, 8'h2B, 8'h00, 0, 8'h71, 1'b0};
      vt[1]  = '{1'b0, 8'h2B, 8'h00, 0, 8'h71, 1'b1};
      vt[2]  = '{1'b1, 8'h2C, 8'hA5, 0, 8'h00, 1'b1};
      vt[3]  = '{1'b0, 8'h2C, 8'h00, 0, 8'hA5, 1'b1};
      vt[4]  = '{1'b1, 8'h90, 8'h33, 0, 8'h00, 1'b0};
      vt[5]  = '{1'b0, 8'h90, 8'h00, 0, 8'h33, 1'b0};
      vt[6]  = '{1'b0, 8'h08, 8'h00, 0, 8'h52, 1'b0};
      vt[7]  = '{1'b0, 8'h48, 8'h00, 1, 8'h12, 1'b0};
      vt[8]  = '{1'b0, 8'h08, 8'h00, 0, 8'h52, 1'b0};
      vt[9]  = '{1'b0, 8'h0F, 8'h00, 3, 8'h55, 1'b1};
      vt[10] = '{1'b1, 8'h0A, 8'h77, 3, 8'h00, 1'b1};
      vt[11] = '{1'b0, 8'h0A, 8'h00, 3, 8'h77, 1'b1};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
      model_reset();
      rst = 1'b1;
      bus.cpu_req = 1'b0;
      bus.cpu_wr = 1'b0;
      bus.cpu_addr = 8'd0;
      bus.cpu_wdata = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_cpu", {bus.cpu_ready, bus.cpu_rdata}, 0);
      chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      chk("rst_dc", {bus.dc_wr, bus.dc_din, bus.dc_line, bus.dc_blk}, 0);
      chk("rst_cnt", {bus.hit_cnt, bus.miss_cnt}, 0);
      rst = 1'b0;

      // Reset in the middle of a refill abandons it
      xs = xq.size();
      @(negedge clk);
      mem_wait = 0;
      bus.cpu_req = 1'b1;
      bus.cpu_wr = 1'b0;
      bus.cpu_addr = 8'h2B;
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      n = 0;
      while (xq.size() - xs < 3 && n < 50) begin
         @(negedge clk);
         #1 n++;
      end
      chk("rf_three_acks", xq.size() - xs >= 3, 1);
      chk("rf_miss_before", bus.miss_cnt, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rf_mem_req", bus.mem_req, 0);
      chk("rf_idle_outs", {bus.dc_wr, bus.dc_line, bus.dc_blk, bus.cpu_ready}, 0);
      chk("rf_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      do_access(1'b0, 8'h2B, 8'h00, 0, rd);
      chk("rf_reread_miss", bus.miss_cnt, 1);

      // Directed table on a cold cache
      do_reset();
      for (int i = 0; i < 12; i++) begin
         h0 = bus.hit_cnt;
         do_access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].w, rd);
         if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_hit", i), bus.hit_cnt != h0, vt[i].exp_hit);
      end

      // cpu_req held high: one access per IDLE visit, hit every third cycle
      xs = xq.size();
      h0 = bus.hit_cnt;
      pulses = 0;
      @(negedge clk);
      bus.cpu_req = 1'b1;
      bus.cpu_wr = 1'b0;
      bus.cpu_addr = 8'h0A;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.cpu_ready) begin
            pulses++;
            chk("held_rdata", bus.cpu_rdata, 8'h77);
         end
      end
      bus.cpu_req = 1'b0;
      for (int k = 0; k < 4; k++) ref_hc = (ref_hc == CMAX) ? CMAX : ref_hc + 1;
      chk("held_pulses", pulses, 4);
      chk("held_hit_cnt", bus.hit_cnt, ref_hc);
      chk("held_no_mem", xq.size() - xs, 0);

      // Random traffic against the reference model
      for (int i = 0; i < 120; i++) begin
         do_access(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 127)), 8'($urandom),
                   $urandom_range(0, 2), rd);
      end

      // Drive the hit counter into saturation
      for (int i = 0; i < 70; i++) do_access(1'b0, 8'h2B, 8'h00, 0, rd);
      chk("hit_saturated", bus.hit_cnt, CMAX);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
